vga_pixel_gen: RTL and testbench

//  Pixel-colour stage directly downstream of vga (clk_div2 + vga_sync). Runs on vga_clk and

---
 rtl/vga_pixel_gen.sv | 210 +++++++++++++++++++++
 tb/tb_vga_pixel_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_gen.sv
// vga_pixel_gen: pixel-colour stage behind the VGA timing generator.
// Draws a background, a 1-px white border and a bouncing box that moves once per
// frame. RGB and the sync/blank signals are registered together, so all DAC-side
// outputs trail their inputs by exactly one clock.
// Ports:
//   clk        pixel clock
//   rst        asynchronous reset, active-low
//   en         1 = box moves on frame ticks, 0 = frozen
//   h_sync     horizontal sync in (active-low)
//   v_sync     vertical sync in (active-low); its falling edge is the frame tick
//   blank_n    1 = active video region
//   pos_x      current pixel column
//   pos_y      current pixel row
//   vga_r/g/b  registered colour
//   h_sync_o   h_sync delayed 1 clk
//   v_sync_o   v_sync delayed 1 clk
//   blank_n_o  blank_n delayed 1 clk
//   frame_cnt  frame ticks seen since reset, wrapping
module vga_pixel_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned STEP     = 2,
  parameter logic [23:0] BG_COLOR = 24'h000040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        blank_n,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        blank_n_o,
  output logic [15:0] frame_cnt
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned CMP_W = POS_W + 1;
  localparam int unsigned RGB_W = 24;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned COL_W = 2;

  localparam logic [POS_W-1:0] LX     = POS_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [POS_W-1:0] LY     = POS_W'(V_ACTIVE - BOX_SIZE);
  localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);
  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_ACTIVE - 1);
  localparam logic [CMP_W-1:0] BOX_W  = CMP_W'(BOX_SIZE);
  localparam logic [CMP_W-1:0] STEP_W = CMP_W'(STEP);

  localparam logic [RGB_W-1:0] WHITE = 24'hFFFFFF;

  // Result of advancing one axis by one frame.
  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             dir_pos;
    logic             bounce;
  } axis_t;

  // Box state
  logic [POS_W-1:0] box_x;
  logic [POS_W-1:0] box_y;
  logic             dir_x;      // 1 = moving towards larger coordinates
  logic             dir_y;
  logic [COL_W-1:0] col_idx;

  // Frame-tick detection
  logic             v_sync_d;
  logic             sync_primed;
  logic             tick_c;

  axis_t            axis_x_c;
  axis_t            axis_y_c;

  logic             in_box_c;
  logic             border_c;
  logic [RGB_W-1:0] palette_c;
  logic [RGB_W-1:0] rgb_c;

  // One axis update: saturate at the limit or at zero and reverse direction there.
  function automatic axis_t axis_step(input logic [POS_W-1:0] pos,
                                      input logic             dir_pos,
                                      input logic [POS_W-1:0] lim);
    axis_t            res;
    logic [CMP_W-1:0] nx;
    res.pos     = pos;
    res.dir_pos = dir_pos;
    res.bounce  = 1'b0;
    nx          = {1'b0, pos} + STEP_W;
    if (dir_pos) begin
      if (nx >= {1'b0, lim}) begin
        res.pos     = lim;
        res.dir_pos = 1'b0;
        res.bounce  = 1'b1;
      end else begin
        res.pos = nx[POS_W-1:0];
      end
    end else begin
      if (pos <= STEP_P) begin
        res.pos     = '0;
        res.dir_pos = 1'b1;
        res.bounce  = 1'b1;
      end else begin
        res.pos = pos - STEP_P;
      end
    end
    return res;
  endfunction

  // Falling edge of v_sync. v_sync_d is only trusted once it has sampled a real
  // clock after reset, so v_sync already low at reset release is not a tick.
  always_comb begin
    tick_c = sync_primed & v_sync_d & ~v_sync;
  end

  // Candidate next positions for both axes
  always_comb begin
    axis_x_c = axis_step(box_x, dir_x, LX);
    axis_y_c = axis_step(box_y, dir_y, LY);
  end

  // Frame counter, box motion and colour index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_sync_d    <= 1'b1;
      sync_primed <= 1'b0;
      frame_cnt   <= '0;
      box_x       <= '0;
      box_y       <= '0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      col_idx     <= '0;
    end else begin
      v_sync_d    <= v_sync;
      sync_primed <= 1'b1;
      if (tick_c) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        if (en) begin
          box_x <= axis_x_c.pos;
          dir_x <= axis_x_c.dir_pos;
          box_y <= axis_y_c.pos;
          dir_y <= axis_y_c.dir_pos;
          // A corner bounce still advances the colour only once.
          if (axis_x_c.bounce || axis_y_c.bounce) begin
            col_idx <= col_idx + COL_W'(1);
          end
        end
      end
    end
  end

  // Box and border hit tests; box compare is done one bit wider so box+size cannot wrap.
  always_comb begin
    in_box_c = ({1'b0, pos_x} >= {1'b0, box_x}) &&
               ({1'b0, pos_x} <  ({1'b0, box_x} + BOX_W)) &&
               ({1'b0, pos_y} >= {1'b0, box_y}) &&
               ({1'b0, pos_y} <  ({1'b0, box_y} + BOX_W));
    border_c = (pos_x == '0) || (pos_x == H_LAST) ||
               (pos_y == '0) || (pos_y == V_LAST);
  end

  // Box palette
  always_comb begin
    palette_c = 24'hFF0000;
    case (col_idx)
      2'd0:    palette_c = 24'hFF0000;
      2'd1:    palette_c = 24'h00FF00;
      2'd2:    palette_c = 24'h0000FF;
      default: palette_c = 24'hFFFF00;
    endcase
  end

  // Colour priority: blank, box, border, background
  always_comb begin
    rgb_c = BG_COLOR;
    if (!blank_n) begin
      rgb_c = '0;
    end else if (in_box_c) begin
      rgb_c = palette_c;
    end else if (border_c) begin
      rgb_c = WHITE;
    end
  end

  // Output register: colour and re-timed syncs stay aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      h_sync_o  <= 1'b1;
      v_sync_o  <= 1'b1;
      blank_n_o <= 1'b0;
    end else begin
      vga_r     <= rgb_c[23:16];
      vga_g     <= rgb_c[15:8];
      vga_b     <= rgb_c[7:0];
      h_sync_o  <= h_sync;
      v_sync_o  <= v_sync;
      blank_n_o <= blank_n;
    end
  end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen: a 640x480 instance and a 64x64 instance
// share all inputs; box positions are inferred by probing rendered pixels.
module tb_vga_pixel_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        h_sync;
  logic        v_sync;
  logic        blank_n;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;

  logic [7:0]  vga_r, vga_g, vga_b;
  logic        h_sync_o, v_sync_o, blank_n_o;
  logic [15:0] frame_cnt;

  logic [7:0]  vga_r2, vga_g2, vga_b2;
  logic        h_sync_o2, v_sync_o2, blank_n_o2;
  logic [15:0] frame_cnt2;

  int total = 0;
  int bad   = 0;

  vga_pixel_gen dut (
    .clk(clk), .rst(rst), .en(en), .h_sync(h_sync), .v_sync(v_sync),
    .blank_n(blank_n), .pos_x(pos_x), .pos_y(pos_y),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .blank_n_o(blank_n_o),
    .frame_cnt(frame_cnt)
  );

  vga_pixel_gen #(.H_ACTIVE(64), .V_ACTIVE(64), .BOX_SIZE(32), .STEP(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .h_sync(h_sync), .v_sync(v_sync),
    .blank_n(blank_n), .pos_x(pos_x), .pos_y(pos_y),
    .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2),
    .h_sync_o(h_sync_o2), .v_sync_o(v_sync_o2), .blank_n_o(blank_n_o2),
    .frame_cnt(frame_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bn;
    logic        hs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic bn, input logic hs, input logic vs, input int x, input int y);
    blank_n = bn;
    h_sync  = hs;
    v_sync  = vs;
    pos_x   = 10'(x);
    pos_y   = 10'(y);
  endtask

  task automatic drive(input logic bn, input logic hs, input logic vs, input int x, input int y);
    set_in(bn, hs, vs, x, y);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pal(input int idx);
    case (idx)
      0:       return 24'hFF0000;
      1:       return 24'h00FF00;
      2:       return 24'h0000FF;
      default: return 24'hFFFF00;
    endcase
  endfunction

  function automatic logic [23:0] outside_col(input int x, input int y, input int h, input int v);
    if (x == 0 || x == h - 1 || y == 0 || y == v - 1) return 24'hFFFFFF;
    return 24'h000040;
  endfunction

  task automatic probe(input int sel, input int x, input int y, input logic [23:0] exp, input string nm);
    drive(1'b1, 1'b1, 1'b1, x, y);
    if (sel == 1) chk(nm, {8'h00, vga_r2, vga_g2, vga_b2}, {8'h00, exp});
    else          chk(nm, {8'h00, vga_r, vga_g, vga_b}, {8'h00, exp});
  endtask

  // Pins the box corner exactly: both inner corners in box colour, neighbours outside it.
  task automatic check_box(input int sel, input int bx, input int by, input int col, input string nm);
    int h;
    int v;
    h = (sel == 1) ? 64 : 640;
    v = (sel == 1) ? 64 : 480;
    probe(sel, bx, by, pal(col), {nm, " tl"});
    probe(sel, bx + 31, by + 31, pal(col), {nm, " br"});
    if (bx > 0) probe(sel, bx - 1, by, outside_col(bx - 1, by, h, v), {nm, " left"});
    if (by > 0) probe(sel, bx, by - 1, outside_col(bx, by - 1, h, v), {nm, " above"});
    probe(sel, bx + 32, by, outside_col(bx + 32, by, h, v), {nm, " right"});
    probe(sel, bx, by + 32, outside_col(bx, by + 32, h, v), {nm, " below"});
  endtask

  // Each tick: v_sync high for one clk then low for one clk.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b1, 0, 0);
      drive(1'b0, 1'b1, 1'b0, 0, 0);
    end
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b1, 1'b1, 0, 0);
    rst = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] prev_sync;

    // priority table with box at (0,0), colour 0
    vecs[0]  = '{1'b1, 1'b1, 10'd100, 10'd100, 24'h000040};
    vecs[1]  = '{1'b1, 1'b0, 10'd0,   10'd200, 24'hFFFFFF};
    vecs[2]  = '{1'b1, 1'b1, 10'd639, 10'd479, 24'hFFFFFF};
    vecs[3]  = '{1'b1, 1'b0, 10'd31,  10'd31,  24'hFF0000};
    vecs[4]  = '{1'b0, 1'b1, 10'd10,  10'd10,  24'h000000};
    vecs[5]  = '{1'b1, 1'b0, 10'd32,  10'd0,   24'hFFFFFF};
    vecs[6]  = '{1'b1, 1'b1, 10'd0,   10'd32,  24'hFFFFFF};
    vecs[7]  = '{1'b1, 1'b1, 10'd32,  10'd31,  24'h000040};
    vecs[8]  = '{1'b0, 1'b0, 10'd31,  10'd32,  24'h000000};
    vecs[9]  = '{1'b1, 1'b1, 10'd31,  10'd32,  24'h000040};
    vecs[10] = '{1'b1, 1'b0, 10'd639, 10'd100, 24'hFFFFFF};
    vecs[11] = '{1'b1, 1'b1, 10'd0,   10'd0,   24'hFF0000};

    // T1: reset with arbitrary inputs
    rst = 1'b1;
    en  = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 123, 45);
    #2;
    rst = 1'b0;
    #1;
    chk("reset rgb async", {8'h00, vga_r, vga_g, vga_b}, 32'h0);
    chk("reset syncs async", 32'({h_sync_o, v_sync_o, blank_n_o}), 32'b110);
    chk("reset frame_cnt async", 32'(frame_cnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'($urandom_range(1)), 1'b0, int'($urandom_range(639)), int'($urandom_range(479)));
      @(posedge clk);
      #1;
    end
    chk("reset rgb held", {8'h00, vga_r, vga_g, vga_b}, 32'h0);
    chk("reset syncs held", 32'({h_sync_o, v_sync_o, blank_n_o}), 32'b110);
    chk("reset frame_cnt held", 32'(frame_cnt), 32'h0);
    // release with v_sync already low: not a tick
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    chk("no tick at release", 32'(frame_cnt), 32'h0);
    drive(1'b0, 1'b1, 1'b1, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    chk("first real tick", 32'(frame_cnt), 32'h1);
    probe(0, 10, 10, 24'hFF0000, "after reset box");

    // T2: priority table, syncs delayed exactly one clock
    prev_sync = 3'b111;
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].bn, vecs[i].hs, 1'b1, int'(vecs[i].x), int'(vecs[i].y));
      #1;
      chk($sformatf("sync hold %0d", i), 32'({h_sync_o, v_sync_o, blank_n_o}), 32'(prev_sync));
      @(posedge clk);
      #1;
      chk($sformatf("prio rgb %0d", i), {8'h00, vga_r, vga_g, vga_b}, {8'h00, vecs[i].rgb});
      chk($sformatf("sync delay %0d", i), 32'({h_sync_o, v_sync_o, blank_n_o}),
          32'({vecs[i].hs, 1'b1, vecs[i].bn}));
      prev_sync = {vecs[i].hs, 1'b1, vecs[i].bn};
    end

    // T3: motion, freeze, long v_sync low
    do_reset();
    en = 1'b1;
    ticks(3);
    check_box(0, 6, 6, 0, "motion 3");
    chk("frame_cnt 3", 32'(frame_cnt), 32'd3);
    en = 1'b0;
    ticks(2);
    check_box(0, 6, 6, 0, "frozen");
    chk("frame_cnt 5", 32'(frame_cnt), 32'd5);
    drive(1'b0, 1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 0, 0);
    chk("long low one tick", 32'(frame_cnt), 32'd6);

    // T4: X bounce. Y bounces first at tick 224 (y=448), so colour is already 1
    // when X reaches 606; Y bounces again at tick 448 (y=0).
    do_reset();
    en = 1'b1;
    ticks(303);
    check_box(0, 606, 290, 1, "x 606");
    ticks(1);
    check_box(0, 608, 288, 2, "x bounce right");
    ticks(1);
    check_box(0, 606, 286, 2, "x back 606");
    ticks(302);
    check_box(0, 2, 318, 3, "x at 2");
    ticks(1);
    check_box(0, 0, 320, 0, "x bounce left");
    chk("frame_cnt 608", 32'(frame_cnt), 32'd608);

    // T5: corner bounce on the 64x64 instance
    do_reset();
    ticks(15);
    check_box(1, 30, 30, 0, "corner pre");
    ticks(1);
    check_box(1, 32, 32, 1, "corner hit");
    ticks(1);
    check_box(1, 30, 30, 1, "corner after");
    chk("frame_cnt2 17", 32'(frame_cnt2), 32'd17);

    // T6: mid-frame reset, then resume
    do_reset();
    ticks(400);
    check_box(0, 416, 96, 2, "pre reset");
    set_in(1'b1, 1'b0, 1'b1, 420, 100);
    #1;
    rst = 1'b0;
    #1;
    chk("mid rst rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h0);
    chk("mid rst syncs", 32'({h_sync_o, v_sync_o, blank_n_o}), 32'b110);
    chk("mid rst frame_cnt", 32'(frame_cnt), 32'h0);
    @(posedge clk);
    #1;
    chk("mid rst rgb held", {8'h00, vga_r, vga_g, vga_b}, 32'h0);
    rst = 1'b1;
    check_box(0, 0, 0, 0, "resume origin");
    ticks(1);
    check_box(0, 2, 2, 0, "resume move");
    chk("resume frame_cnt", 32'(frame_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
